// File: rtl/mem_pkg.sv
// mem_pkg: shared types, range limits and parity helper for mem_param
package mem_pkg;
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} mem_state_t;
  localparam int MAX_RD_LATENCY = 4;
  localparam int MAX_DATA_WIDTH = 64;
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: L-deep read pipeline shifting {valid, payload}, flushed by sync reset
//   i_valid/i_data  stage-1 capture of an accepted read
//   o_valid/o_data  last stage; payload only advances with valid, so o_data holds the last read
module mem_rd_pipe #(
  parameter int W = 8,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [L-1:0] r_v;
  logic [W-1:0] r_d [L];
  logic [L:0]   w_vin;
  logic [W-1:0] w_din [L+1];
  always_comb begin
    w_vin = {r_v, i_valid};
    w_din[0] = i_data;
    for (int i = 0; i < L; i++) w_din[i+1] = r_d[i];
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < L; i++) r_d[i] <= '0;
    end else begin
      r_v <= w_vin[L-1:0];
      for (int i = 0; i < L; i++) if (w_vin[i]) r_d[i] <= w_din[i];
    end
  assign o_valid = r_v[L-1];
  assign o_data  = r_d[L-1];
endmodule

// File: rtl/mem_param.sv
// mem_param: parametrised single-port register file with init sweep and pipelined reads
//   clk, reset (sync, active high); address/write_en/read_en/data_wr request inputs
//   data_rd/rd_valid read response; init_busy during clear sweep; req_drop flags ignored requests
//   MEM_PARITY_EN adds err_inject (corrupt stored parity) and parity_err (with rd_valid)
module mem_param import mem_pkg::*; #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_wr,
`ifdef MEM_PARITY_EN
  input  logic                  err_inject,
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  req_drop
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef MEM_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY || DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad
    $error("mem_param: parameter out of range");
  end
  mem_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_drop;
  logic [SW-1:0]         r_mem [DEPTH];
  logic                  w_idle;
  logic [SW-1:0]         w_wr_word, w_rd_word, w_pipe_in, w_pipe_out;
  assign w_idle    = r_state == ST_IDLE;
  assign w_rd_word = r_mem[address];
`ifdef MEM_PARITY_EN
  assign w_wr_word  = {calc_parity(MAX_DATA_WIDTH'(data_wr)) ^ err_inject, data_wr};
  assign w_pipe_in  = {calc_parity(MAX_DATA_WIDTH'(w_rd_word[DATA_WIDTH-1:0])) ^ w_rd_word[DATA_WIDTH],
                       w_rd_word[DATA_WIDTH-1:0]};
  assign parity_err = rd_valid & w_pipe_out[DATA_WIDTH];
`else
  assign w_wr_word = data_wr;
  assign w_pipe_in = w_rd_word;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= !w_idle && (write_en || read_en);
      if (!w_idle) begin
        r_ptr <= r_ptr + 1'b1;
        if (&r_ptr) r_state <= ST_IDLE;
      end
    end
  // An all-zero word also carries correct even parity, so the sweep writes '0 in both builds
  always_ff @(posedge clk)
    if (!reset) begin
      if (!w_idle) r_mem[r_ptr] <= '0;
      else if (write_en) r_mem[address] <= w_wr_word;
    end
  mem_rd_pipe #(.W(SW), .L(RD_LATENCY)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_idle && read_en),
    .i_data  (w_pipe_in),
    .o_valid (rd_valid),
    .o_data  (w_pipe_out)
  );
  assign data_rd   = w_pipe_out[DATA_WIDTH-1:0];
  assign init_busy = !w_idle;
  assign req_drop  = r_drop;
endmodule

// File: tb/tb_mem_param.sv
// tb_mem_param: directed stimulus with a queue scoreboard checking read data, latency and parity
module tb_mem_param;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int L  = 3;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_wr = '0;
  logic [DW-1:0] data_rd;
  logic          rd_valid, init_busy, req_drop;
`ifdef MEM_PARITY_EN
  logic          err_inject = 1'b0;
  logic          parity_err;
`endif
  typedef struct {logic [DW-1:0] d; logic p; int due;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_wr   (data_wr),
`ifdef MEM_PARITY_EN
    .err_inject(err_inject),
    .parity_err(parity_err),
`endif
    .data_rd   (data_rd),
    .rd_valid  (rd_valid),
    .init_busy (init_busy),
    .req_drop  (req_drop)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj = 1'b0);
    write_en = 1'b1; address = a; data_wr = d;
`ifdef MEM_PARITY_EN
    err_inject = inj;
`endif
    tick;
    write_en = 1'b0;
`ifdef MEM_PARITY_EN
    err_inject = 1'b0;
`endif
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic p = 1'b0);
    read_en = 1'b1; address = a;
    q.push_back('{e, p, cyc + L});
    tick;
    read_en = 1'b0;
  endtask
  task automatic rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
    write_en = 1'b1; read_en = 1'b1; address = a; data_wr = d;
    q.push_back('{e, 1'b0, cyc + L});
    tick;
    write_en = 1'b0; read_en = 1'b0;
  endtask
  task automatic do_reset(input int n);
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    reset = 1'b1;
    repeat (n) tick;
    reset = 1'b0; read_en = 1'b0; write_en = 1'b0;
    chk("rst_data_rd", data_rd, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_req_drop", req_drop, 0);
  endtask
  task automatic init_chk(input bit poke);
    for (int i = 0; i < 4; i++) begin
      chk("init_busy_hi", init_busy, 1);
      if (poke && i == 3) begin
        read_en = 1'b1; write_en = 1'b1; address = 0; data_wr = 8'hFF;
      end
      tick;
      read_en = 1'b0; write_en = 1'b0;
    end
    chk("init_busy_lo", init_busy, 0);
    chk("req_drop_pulse", req_drop, poke);
    tick;
    chk("req_drop_clear", req_drop, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rd_valid: got data %0h with no read outstanding (cycle %0d)", data_rd, cyc);
      end else begin
        e = q.pop_front();
        chk("rd_data", data_rd, e.d);
        chk("rd_latency_cycle", cyc, e.due);
`ifdef MEM_PARITY_EN
        chk("parity_err", parity_err, e.p);
`endif
      end
    end
  end
  initial begin
    do_reset(2);
    init_chk(0);
    for (int i = 0; i < 4; i++) rd(i[AW-1:0], 8'h00);
    wr(2, 8'hA5);
    rd(2, 8'hA5);
    wr(1, 8'h11);
    rw(1, 8'h22, 8'h11);
    rd(1, 8'h22);
    repeat (L + 1) tick;
    do_reset(1);
    init_chk(1);
    rd(0, 8'h00);
    for (int i = 0; i < 4; i++) wr(i[AW-1:0], 8'h10 + 8'(i));
    rd(0, 8'h10);
    rd(1, 8'h11);
    rd(2, 8'h12);
    read_en = 1'b1; address = 3;
    do_reset(1);
    init_chk(0);
    rd(0, 8'h00);
`ifdef MEM_PARITY_EN
    wr(1, 8'h3C, 1'b1);
    rd(1, 8'h3C, 1'b1);
    wr(1, 8'h3C);
    rd(1, 8'h3C, 1'b0);
`endif
    repeat (L + 2) tick;
    while (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL missing_rd_valid: expected data %0h due cycle %0d never arrived", q[0].d, q[0].due);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_param.md
# mem_param

Parametrised single-port register-file memory: the next-generation DUT behind the memory test interface, generalised from the fixed 4×8-bit memory. Adds configurable address/data width, configurable read latency with a `rd_valid` strobe, and a self-clearing init sequence after reset. Sits directly under the testbench top, driven by the driver clocking block and sampled by the monitor clocking block.

## Interface
- `ADDR_WIDTH`, default 2: address bits; depth is DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: word width, legal range 1..64.
- `RD_LATENCY`, default 1: cycles from read request to `rd_valid`, legal range 1..4.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  ADDR_WIDTH  word address for read and write.
- `write_en`  in  1  write request this cycle.
- `read_en`  in  1  read request this cycle.
- `data_wr`  in  DATA_WIDTH  write data.
- `data_rd`  out  DATA_WIDTH  read data; valid when `rd_valid`=1.
- `rd_valid`  out  1  one-cycle strobe per accepted read.
- `init_busy`  out  1  high while the init sweep runs.
- `req_drop`  out  1  one-cycle pulse when a request is ignored.
- `err_inject`  in  1  present only with MEM_PARITY_EN; flips the stored parity bit of the current write.
- `parity_err`  out  1  present only with MEM_PARITY_EN; qualified by `rd_valid`.

## Operation
- FSM states: ST_INIT and ST_IDLE.
- Reset forces ST_INIT with the clear pointer at 0 and the read pipeline flushed.
- ST_INIT:
  - Writes 0, with correct parity, to word[ptr] each cycle and increments ptr.
  - After word DEPTH-1 is written, moves to ST_IDLE on the next edge.
  - The sweep takes exactly DEPTH cycles.
- Requests in ST_INIT (`write_en` or `read_en` high) are not performed. `req_drop`=1 in the following cycle.
- ST_IDLE write: `write_en`=1 stores `data_wr` to word[address] at the edge.
- ST_IDLE read: `read_en`=1 captures word[address] into stage 1 of the read pipeline, which is RD_LATENCY stages deep.
- `read_en` and `write_en` together on the same address: read-first. The read returns the old contents and the write still lands.
- One read may be accepted per cycle, fully pipelined, with no back-pressure.
- `data_rd` holds the last valid read value until the next `rd_valid`.
- Widths: the address is used unmodified; no wrap logic is needed because DEPTH = 2**ADDR_WIDTH covers all address values.

## Timing
- Reset values: `data_rd`=0, `rd_valid`=0, `req_drop`=0, `parity_err`=0.
- `init_busy`=1 from the first cycle after reset is sampled high. It falls after DEPTH cycles.
- With `reset` high at edge N:
  - Cycles N+1 .. N+DEPTH are ST_INIT (`init_busy`=1).
  - The first request accepted is one sampled at edge N+DEPTH+1.
- Read request sampled at edge T gives `rd_valid`=1 and valid `data_rd` in the cycle after edge T+RD_LATENCY-1. At RD_LATENCY=1, data appears the cycle after the request edge.
- Write at edge T is visible to a read sampled at edge T+1.
- Reset mid-operation:
  - In-flight reads are discarded; no `rd_valid` is emitted for them.
  - The init sweep restarts from word 0.
- Reset mid-init: restarts the sweep from word 0.

## Configuration
- `MEM_PARITY_EN` defined:
  - Each word stores DATA_WIDTH+1 bits, with the extra bit as even parity computed from `data_wr` on write.
  - `err_inject`=1 with `write_en` stores the inverted parity bit.
  - On read, parity is recomputed. `parity_err`=1 in the same cycle as `rd_valid` on mismatch, 0 otherwise.
  - Init writes correct parity.
- `MEM_PARITY_EN` undefined:
  - No parity storage.
  - The `err_inject` and `parity_err` ports do not exist.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum (ST_INIT, ST_IDLE).
  - Parameter range-check constants (MAX_RD_LATENCY=4, MAX_DATA_WIDTH=64).
  - Even-parity function `calc_parity`.
- Sub-module `mem_rd_pipe`: a RD_LATENCY-deep shift of {valid, data[, parity_err]}, with synchronous flush on `reset`.
- The top holds the FSM, the clear pointer and the storage array.

## Test plan
- Reset with ADDR_WIDTH=2, then hold `reset` low → `init_busy`=1 for exactly 4 cycles; reads afterwards of addresses 0..3 return 0x00.
- Write 0xA5 to addr 2, read addr 2 on the next cycle, RD_LATENCY=3 → `rd_valid` with `data_rd`=0xA5 exactly 3 cycles after the read edge.
- Addr 1 holds 0x11; same cycle `write_en`+`read_en` to addr 1 with `data_wr`=0x22 → read returns 0x11; a following read returns 0x22.
- `read_en` during init → no `rd_valid`, `req_drop` pulses once; memory is unchanged.
- Back-to-back reads of addrs 0,1,2,3 holding 0x10..0x13, then `reset` asserted in the cycle after the third read → only the reads whose `rd_valid` has already appeared are observed; init restarts.
- MEM_PARITY_EN: write 0x3C with `err_inject`=1, then read → `parity_err`=1 with `rd_valid`. Rewriting without inject and reading → `parity_err`=0.
